// File: rtl/csr_pkg.sv
// Shared CSR addresses, field positions, write masks and exception codes
// for the CSR/exception unit and its timer.
package csr_pkg;

   localparam int unsigned CSR_AW = 14;

   localparam logic [CSR_AW-1:0] CSR_CRMD   = 14'h000;
   localparam logic [CSR_AW-1:0] CSR_PRMD   = 14'h001;
   localparam logic [CSR_AW-1:0] CSR_ECFG   = 14'h004;
   localparam logic [CSR_AW-1:0] CSR_ESTAT  = 14'h005;
   localparam logic [CSR_AW-1:0] CSR_ERA    = 14'h006;
   localparam logic [CSR_AW-1:0] CSR_BADV   = 14'h007;
   localparam logic [CSR_AW-1:0] CSR_EENTRY = 14'h00C;
   localparam logic [CSR_AW-1:0] CSR_SAVE0  = 14'h030;
   localparam logic [CSR_AW-1:0] CSR_SAVE1  = 14'h031;
   localparam logic [CSR_AW-1:0] CSR_SAVE2  = 14'h032;
   localparam logic [CSR_AW-1:0] CSR_SAVE3  = 14'h033;
   localparam logic [CSR_AW-1:0] CSR_TID    = 14'h040;
   localparam logic [CSR_AW-1:0] CSR_TCFG   = 14'h041;
   localparam logic [CSR_AW-1:0] CSR_TVAL   = 14'h042;
   localparam logic [CSR_AW-1:0] CSR_TICLR  = 14'h044;

   localparam int unsigned CRMD_PLV       = 0;
   localparam int unsigned CRMD_IE        = 2;
   localparam int unsigned PRMD_PPLV      = 0;
   localparam int unsigned PRMD_PIE       = 2;
   localparam int unsigned ESTAT_IS_HI    = 12;
   localparam int unsigned ESTAT_ECODE_LO = 16;
   localparam int unsigned ESTAT_ESUB_LO  = 22;
   localparam int unsigned IS_HW_LO       = 2;
   localparam int unsigned IS_TI          = 11;
   localparam int unsigned IS_IPI         = 12;
   localparam int unsigned TCFG_EN        = 0;
   localparam int unsigned TCFG_PERIODIC  = 1;

   // Software-writable bits of each register; everything else is held or read-only.
   localparam logic [31:0] CRMD_WMASK   = 32'h0000_001F;
   localparam logic [31:0] PRMD_WMASK   = 32'h0000_0007;
   localparam logic [31:0] ECFG_WMASK   = 32'h0000_1BFF;
   localparam logic [31:0] ESTAT_WMASK  = 32'h0000_0003;
   localparam logic [31:0] EENTRY_WMASK = 32'hFFFF_FFC0;
   localparam logic [31:0] FULL_WMASK   = 32'hFFFF_FFFF;

   localparam logic [5:0] ECODE_INT  = 6'h00;
   localparam logic [5:0] ECODE_ADEF = 6'h08;
   localparam logic [5:0] ECODE_ALE  = 6'h09;
   localparam logic [5:0] ECODE_SYS  = 6'h0B;
   localparam logic [5:0] ECODE_BRK  = 6'h0C;
   localparam logic [5:0] ECODE_INE  = 6'h0D;

   function automatic logic [31:0] csr_merge(input logic [31:0] old_v,
                                             input logic [31:0] wv,
                                             input logic [31:0] wm,
                                             input logic [31:0] field);
      return (old_v & ~(wm & field)) | (wv & wm & field);
   endfunction

endpackage

// File: rtl/csr_timer.sv
// Stable timer: TCFG/TVAL countdown with periodic or one-shot expiry,
// timer-interrupt flag with TICLR clear, and the free-running 64-bit counter.
module csr_timer
   import csr_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        tcfg_we,
   input  logic        ticlr,
   input  logic [31:0] wvalue,
   input  logic [31:0] wmask,
   output logic [31:0] tcfg,
   output logic [31:0] tval,
   output logic        timer_int,
   output logic [63:0] timer_64
);

   logic [31:0] tcfg_q, tcfg_d;
   logic [31:0] tval_q, tval_d;
   logic        ti_q, ti_d;
   logic [63:0] cnt_q, cnt_d;

   // Clear first so a same-cycle expiry set takes precedence over TICLR.
   always_comb begin
      tcfg_d = tcfg_q;
      tval_d = tval_q;
      ti_d   = ti_q;
      cnt_d  = cnt_q + 64'd1;
      if (ticlr) ti_d = 1'b0;
      if (tcfg_we) begin
         tcfg_d = csr_merge(tcfg_q, wvalue, wmask, FULL_WMASK);
         tval_d = {tcfg_d[31:2], 2'b00};
      end else if (tcfg_q[TCFG_EN]) begin
         if (tval_q == 32'h0) begin
            ti_d   = 1'b1;
            tval_d = tcfg_q[TCFG_PERIODIC] ? {tcfg_q[31:2], 2'b00} : 32'hFFFF_FFFF;
         end else if (tval_q != 32'hFFFF_FFFF) begin
            tval_d = tval_q - 32'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tcfg_q <= 32'h0;
         tval_q <= 32'hFFFF_FFFF;
         ti_q   <= 1'b0;
         cnt_q  <= 64'h0;
      end else begin
         tcfg_q <= tcfg_d;
         tval_q <= tval_d;
         ti_q   <= ti_d;
         cnt_q  <= cnt_d;
      end
   end

   assign tcfg      = tcfg_q;
   assign tval      = tval_q;
   assign timer_int = ti_q;
   assign timer_64  = cnt_q;

endmodule

// File: rtl/csr_exc_unit.sv
// CSR register file and exception/ertn commit endpoint: CSR accesses,
// exception state capture, same-cycle redirect target and interrupt pending.
module csr_exc_unit
   import csr_pkg::*;
#(
   parameter logic [31:0] TID_INIT   = 32'h0,
   parameter logic [31:0] EENTRY_RST = 32'h0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [13:0] csr_num,
   output logic [31:0] csr_rvalue,
   input  logic        csr_we,
   input  logic [31:0] csr_wmask,
   input  logic [31:0] csr_wvalue,
   input  logic        exception_submit,
   input  logic [5:0]  ecode_submit,
   input  logic [8:0]  esubcode_submit,
   input  logic [31:0] exception_pc_submit,
   input  logic [31:0] exception_maddr_submit,
   input  logic        ertn_submit,
   input  logic [7:0]  hw_int_in,
   input  logic        ipi_int_in,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc,
   output logic        has_int,
   output logic [31:0] csr_tid,
   output logic [63:0] timer_64
);

   logic [31:0] crmd_q, crmd_d, prmd_q, prmd_d, ecfg_q, ecfg_d;
   logic [31:0] estat_q, estat_d, era_q, era_d, badv_q, badv_d;
   logic [31:0] eentry_q, eentry_d, tid_q, tid_d;
   logic [3:0][31:0] save_q, save_d;
   logic [31:0] tcfg, tval, estat_rd;
   logic        timer_int, wr_en, tcfg_we, ticlr;

   // An exception in the same cycle suppresses any CSR write.
   assign wr_en   = csr_we & ~exception_submit;
   assign tcfg_we = wr_en && (csr_num == CSR_TCFG);
   assign ticlr   = wr_en && (csr_num == CSR_TICLR) && csr_wvalue[0] && csr_wmask[0];

   csr_timer u_timer (
      .clk       (clk),
      .rst       (rst),
      .tcfg_we   (tcfg_we),
      .ticlr     (ticlr),
      .wvalue    (csr_wvalue),
      .wmask     (csr_wmask),
      .tcfg      (tcfg),
      .tval      (tval),
      .timer_int (timer_int),
      .timer_64  (timer_64)
   );

   always_comb begin
      crmd_d   = crmd_q;
      prmd_d   = prmd_q;
      ecfg_d   = ecfg_q;
      estat_d  = estat_q;
      era_d    = era_q;
      badv_d   = badv_q;
      eentry_d = eentry_q;
      tid_d    = tid_q;
      save_d   = save_q;
      if (wr_en) begin
         case (csr_num)
            CSR_CRMD:   crmd_d   = csr_merge(crmd_q, csr_wvalue, csr_wmask, CRMD_WMASK);
            CSR_PRMD:   prmd_d   = csr_merge(prmd_q, csr_wvalue, csr_wmask, PRMD_WMASK);
            CSR_ECFG:   ecfg_d   = csr_merge(ecfg_q, csr_wvalue, csr_wmask, ECFG_WMASK);
            CSR_ESTAT:  estat_d  = csr_merge(estat_q, csr_wvalue, csr_wmask, ESTAT_WMASK);
            CSR_ERA:    era_d    = csr_merge(era_q, csr_wvalue, csr_wmask, FULL_WMASK);
            CSR_BADV:   badv_d   = csr_merge(badv_q, csr_wvalue, csr_wmask, FULL_WMASK);
            CSR_EENTRY: eentry_d = csr_merge(eentry_q, csr_wvalue, csr_wmask, EENTRY_WMASK);
            CSR_TID:    tid_d    = csr_merge(tid_q, csr_wvalue, csr_wmask, FULL_WMASK);
            CSR_SAVE0, CSR_SAVE1, CSR_SAVE2, CSR_SAVE3:
               save_d[csr_num[1:0]] = csr_merge(save_q[csr_num[1:0]], csr_wvalue,
                                                csr_wmask, FULL_WMASK);
            default: ;
         endcase
      end
      estat_d[IS_HW_LO +: 8] = hw_int_in;
      estat_d[IS_IPI]        = ipi_int_in;
      if (exception_submit) begin
         prmd_d[PRMD_PPLV +: 2]         = crmd_q[CRMD_PLV +: 2];
         prmd_d[PRMD_PIE]               = crmd_q[CRMD_IE];
         crmd_d[CRMD_PLV +: 2]          = 2'b00;
         crmd_d[CRMD_IE]                = 1'b0;
         era_d                          = exception_pc_submit;
         estat_d[ESTAT_ECODE_LO +: 6]   = ecode_submit;
         estat_d[ESTAT_ESUB_LO +: 9]    = esubcode_submit;
         if (ecode_submit == ECODE_ADEF)     badv_d = exception_pc_submit;
         else if (ecode_submit == ECODE_ALE) badv_d = exception_maddr_submit;
      end else if (ertn_submit) begin
         crmd_d[CRMD_PLV +: 2] = prmd_q[PRMD_PPLV +: 2];
         crmd_d[CRMD_IE]       = prmd_q[PRMD_PIE];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         crmd_q   <= 32'h0000_0008;
         prmd_q   <= 32'h0;
         ecfg_q   <= 32'h0;
         estat_q  <= 32'h0;
         era_q    <= 32'h0;
         badv_q   <= 32'h0;
         eentry_q <= EENTRY_RST;
         tid_q    <= TID_INIT;
         save_q   <= '0;
      end else begin
         crmd_q   <= crmd_d;
         prmd_q   <= prmd_d;
         ecfg_q   <= ecfg_d;
         estat_q  <= estat_d;
         era_q    <= era_d;
         badv_q   <= badv_d;
         eentry_q <= eentry_d;
         tid_q    <= tid_d;
         save_q   <= save_d;
      end
   end

   // The timer interrupt flag lives in the timer; splice it into ESTAT.IS[11].
   assign estat_rd = {estat_q[31:IS_TI+1], timer_int, estat_q[IS_TI-1:0]};

   always_comb begin
      csr_rvalue = 32'h0;
      case (csr_num)
         CSR_CRMD:   csr_rvalue = crmd_q;
         CSR_PRMD:   csr_rvalue = prmd_q;
         CSR_ECFG:   csr_rvalue = ecfg_q;
         CSR_ESTAT:  csr_rvalue = estat_rd;
         CSR_ERA:    csr_rvalue = era_q;
         CSR_BADV:   csr_rvalue = badv_q;
         CSR_EENTRY: csr_rvalue = eentry_q;
         CSR_SAVE0, CSR_SAVE1, CSR_SAVE2, CSR_SAVE3:
                     csr_rvalue = save_q[csr_num[1:0]];
         CSR_TID:    csr_rvalue = tid_q;
         CSR_TCFG:   csr_rvalue = tcfg;
         CSR_TVAL:   csr_rvalue = tval;
         default:    csr_rvalue = 32'h0;
      endcase
   end

   assign has_int        = (|(estat_rd[ESTAT_IS_HI:0] & ecfg_q[ESTAT_IS_HI:0])) & crmd_q[CRMD_IE];
   assign redirect_valid = exception_submit | ertn_submit;
   assign redirect_pc    = exception_submit ? eentry_q : era_q;
   assign csr_tid        = tid_q;

endmodule

// File: tb/tb_csr_exc_unit.sv
// Scoreboard bench for csr_exc_unit: directed stimulus queues expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_csr_exc_unit;
   import csr_pkg::*;

   localparam logic [31:0] TID_P    = 32'h1234_5678;
   localparam logic [31:0] EENTRY_P = 32'h1C00_0000;
   localparam int K_RD  = 0;
   localparam int K_INT = 1;
   localparam int K_TID = 2;
   localparam int K_T64 = 3;

   typedef struct {
      string       name;
      int          kind;
      logic [63:0] exp;
   } chk_t;

   logic        clk, rst;
   logic [13:0] csr_num;
   logic [31:0] csr_rvalue, csr_wmask, csr_wvalue;
   logic        csr_we, exception_submit, ertn_submit, ipi_int_in;
   logic [5:0]  ecode_submit;
   logic [8:0]  esubcode_submit;
   logic [31:0] exception_pc_submit, exception_maddr_submit;
   logic [7:0]  hw_int_in;
   logic        redirect_valid, has_int;
   logic [31:0] redirect_pc, csr_tid;
   logic [63:0] timer_64;

   chk_t        chk_q[$];
   logic [31:0] redir_q[$];
   chk_t        mon_c;
   logic [63:0] mon_act;
   logic [31:0] mon_rp;
   logic [63:0] cyc_model;
   int          checks, failures;

   csr_exc_unit #(.TID_INIT(TID_P), .EENTRY_RST(EENTRY_P)) dut (
      .clk(clk), .rst(rst), .csr_num(csr_num), .csr_rvalue(csr_rvalue),
      .csr_we(csr_we), .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue),
      .exception_submit(exception_submit), .ecode_submit(ecode_submit),
      .esubcode_submit(esubcode_submit), .exception_pc_submit(exception_pc_submit),
      .exception_maddr_submit(exception_maddr_submit), .ertn_submit(ertn_submit),
      .hw_int_in(hw_int_in), .ipi_int_in(ipi_int_in), .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc), .has_int(has_int), .csr_tid(csr_tid), .timer_64(timer_64)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference for the free-running counter.
   always @(posedge clk or posedge rst) begin
      if (rst) cyc_model <= 64'h0;
      else     cyc_model <= cyc_model + 64'd1;
   end

   always @(negedge clk) begin
      if (redirect_valid) begin
         checks++;
         if (redir_q.size() == 0) begin
            failures++;
            $display("FAIL redirect_unexpected: got pc %h, required no redirect", redirect_pc);
         end else begin
            mon_rp = redir_q.pop_front();
            if (redirect_pc !== mon_rp) begin
               failures++;
               $display("FAIL redirect_pc: got %h required %h", redirect_pc, mon_rp);
            end
         end
      end else if (redir_q.size() != 0) begin
         checks++;
         failures++;
         mon_rp = redir_q.pop_front();
         $display("FAIL redirect_missing: got no redirect, required pc %h", mon_rp);
      end
      while (chk_q.size() != 0) begin
         mon_c = chk_q.pop_front();
         case (mon_c.kind)
            K_RD:    mon_act = 64'(csr_rvalue);
            K_INT:   mon_act = 64'(has_int);
            K_TID:   mon_act = 64'(csr_tid);
            default: mon_act = timer_64;
         endcase
         checks++;
         if (mon_act !== mon_c.exp) begin
            failures++;
            $display("FAIL %s: got %h required %h", mon_c.name, mon_act, mon_c.exp);
         end
      end
   end

   task automatic push_chk(input string n, input int k, input logic [63:0] e);
      chk_t c;
      c.name = n;
      c.kind = k;
      c.exp  = e;
      chk_q.push_back(c);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input logic [13:0] num, input logic [31:0] e, input string n);
      csr_num = num;
      push_chk(n, K_RD, 64'(e));
      tick();
   endtask

   task automatic wr(input logic [13:0] num, input logic [31:0] v, input logic [31:0] m);
      csr_num    = num;
      csr_wvalue = v;
      csr_wmask  = m;
      csr_we     = 1'b1;
      tick();
      csr_we     = 1'b0;
   endtask

   task automatic commit(input logic exc, input logic ertn, input logic [5:0] ec,
                         input logic [8:0] esc, input logic [31:0] pc,
                         input logic [31:0] maddr, input logic [31:0] exp_pc);
      exception_submit       = exc;
      ertn_submit            = ertn;
      ecode_submit           = ec;
      esubcode_submit        = esc;
      exception_pc_submit    = pc;
      exception_maddr_submit = maddr;
      redir_q.push_back(exp_pc);
      tick();
      exception_submit = 1'b0;
      ertn_submit      = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      checks = 0; failures = 0;
      rst = 1'b1; csr_num = 14'h0; csr_we = 1'b0; csr_wmask = 32'h0; csr_wvalue = 32'h0;
      exception_submit = 1'b0; ertn_submit = 1'b0; ecode_submit = 6'h0;
      esubcode_submit = 9'h0; exception_pc_submit = 32'h0; exception_maddr_submit = 32'h0;
      hw_int_in = 8'h0; ipi_int_in = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Reset state
      push_chk("t64_reset", K_T64, cyc_model);
      push_chk("has_int_reset", K_INT, 64'd0);
      push_chk("tid_reset", K_TID, 64'(TID_P));
      rd(CSR_CRMD, 32'h8, "crmd_reset");
      rd(CSR_TVAL, 32'hFFFF_FFFF, "tval_reset");
      rd(CSR_EENTRY, EENTRY_P, "eentry_reset");
      rd(CSR_TICLR, 32'h0, "ticlr_reads0");
      rd(14'h002, 32'h0, "unmapped_reads0");

      // Exception from PLV3/IE=1
      wr(CSR_EENTRY, 32'h1C00_803F, FULL_WMASK);
      rd(CSR_EENTRY, 32'h1C00_8000, "eentry_low_ro");
      wr(CSR_CRMD, 32'h7, 32'h7);
      rd(CSR_CRMD, 32'hF, "crmd_plv3_ie");
      commit(1'b1, 1'b0, ECODE_SYS, 9'h0, 32'h1C00_0040, 32'h0, 32'h1C00_8000);
      rd(CSR_ERA, 32'h1C00_0040, "era_sys");
      rd(CSR_PRMD, 32'h7, "prmd_sys");
      rd(CSR_CRMD, 32'h8, "crmd_sys");
      rd(CSR_ESTAT, 32'h000B_0000, "estat_sys");

      // Ertn restores
      commit(1'b0, 1'b1, 6'h0, 9'h0, 32'h0, 32'h0, 32'h1C00_0040);
      rd(CSR_CRMD, 32'hF, "crmd_ertn");
      push_chk("t64_run", K_T64, cyc_model);
      rd(CSR_PRMD, 32'h7, "prmd_ertn");

      // ALE with a same-cycle CSR write that must be dropped
      csr_num = CSR_SAVE0; csr_wvalue = 32'h0000_DEAD; csr_wmask = FULL_WMASK; csr_we = 1'b1;
      commit(1'b1, 1'b0, ECODE_ALE, 9'h0, 32'h1C00_0080, 32'h0000_1003, 32'h1C00_8000);
      csr_we = 1'b0;
      rd(CSR_BADV, 32'h0000_1003, "badv_ale");
      rd(CSR_SAVE0, 32'h0, "save0_blocked");
      rd(CSR_ERA, 32'h1C00_0080, "era_ale");
      rd(CSR_ESTAT, 32'h0009_0000, "estat_ale");

      // Exception and ertn together: exception wins
      commit(1'b1, 1'b1, ECODE_SYS, 9'h0, 32'h1C00_00C0, 32'h0000_5555, 32'h1C00_8000);
      rd(CSR_CRMD, 32'h8, "crmd_exc_ertn");
      rd(CSR_PRMD, 32'h0, "prmd_exc_ertn");
      rd(CSR_ERA, 32'h1C00_00C0, "era_exc_ertn");
      rd(CSR_BADV, 32'h0000_1003, "badv_hold");

      // ADEF with subcode
      commit(1'b1, 1'b0, ECODE_ADEF, 9'h1, 32'h1C00_00F4, 32'h0, 32'h1C00_8000);
      rd(CSR_BADV, 32'h1C00_00F4, "badv_adef");
      rd(CSR_ESTAT, 32'h0048_0000, "estat_adef");

      // Masked writes and field protection
      wr(CSR_SAVE2, 32'h0000_CAFE, 32'h0000_FF00);
      rd(CSR_SAVE2, 32'h0000_CA00, "save2_masked");
      wr(CSR_TID, 32'hABCD_0001, FULL_WMASK);
      push_chk("tid_port", K_TID, 64'h0000_0000_ABCD_0001);
      rd(CSR_TID, 32'hABCD_0001, "tid_rd");
      wr(CSR_ESTAT, 32'hFFFF_FFFF, FULL_WMASK);
      rd(CSR_ESTAT, 32'h0048_0003, "estat_sw_only");
      wr(CSR_ESTAT, 32'h0, FULL_WMASK);
      rd(CSR_ESTAT, 32'h0048_0000, "estat_sw_clr");
      wr(CSR_CRMD, 32'h4, 32'h4);
      wr(CSR_ECFG, 32'hFFFF_FFFF, FULL_WMASK);
      rd(CSR_ECFG, 32'h0000_1BFF, "ecfg_mask");
      wr(CSR_ECFG, 32'h0000_0800, FULL_WMASK);

      // Periodic timer: InitVal=4 -> TVAL 0x10 down to 0, then reload
      wr(CSR_TCFG, 32'h0000_0013, FULL_WMASK);
      for (int i = 0; i < 18; i++) begin
         push_chk("has_int_periodic", K_INT, 64'(i == 17));
         rd(CSR_TVAL, (i <= 16) ? 32'(16 - i) : 32'h10, "tval_periodic");
      end
      rd(CSR_ESTAT, 32'h0048_0800, "estat_ti_set");
      wr(CSR_TICLR, 32'h1, FULL_WMASK);
      push_chk("has_int_ticlr", K_INT, 64'd0);
      rd(CSR_ESTAT, 32'h0048_0000, "estat_ti_clr");
      repeat (12) tick();
      wr(CSR_TICLR, 32'h1, FULL_WMASK);
      push_chk("has_int_set_wins", K_INT, 64'd1);
      rd(CSR_ESTAT, 32'h0048_0800, "estat_set_wins");

      // One-shot timer
      wr(CSR_TCFG, 32'h0, FULL_WMASK);
      wr(CSR_TICLR, 32'h1, FULL_WMASK);
      rd(CSR_ESTAT, 32'h0048_0000, "estat_pre_oneshot");
      wr(CSR_TCFG, 32'h0000_0011, FULL_WMASK);
      repeat (16) tick();
      push_chk("has_int_oneshot_pre", K_INT, 64'd0);
      rd(CSR_TVAL, 32'h0, "tval_oneshot_zero");
      push_chk("has_int_oneshot", K_INT, 64'd1);
      rd(CSR_TVAL, 32'hFFFF_FFFF, "tval_oneshot_hold");
      repeat (5) tick();
      rd(CSR_TVAL, 32'hFFFF_FFFF, "tval_oneshot_stay");
      wr(CSR_TICLR, 32'h1, FULL_WMASK);
      repeat (20) tick();
      push_chk("has_int_oneshot_once", K_INT, 64'd0);
      rd(CSR_ESTAT, 32'h0048_0000, "estat_oneshot_once");

      // Hardware interrupt line sampled into IS[2]
      wr(CSR_ECFG, 32'h0000_0004, FULL_WMASK);
      hw_int_in = 8'h01;
      push_chk("has_int_hw_pre", K_INT, 64'd0);
      rd(CSR_ESTAT, 32'h0048_0000, "estat_hw_pre");
      push_chk("has_int_hw", K_INT, 64'd1);
      rd(CSR_ESTAT, 32'h0048_0004, "estat_hw");

      // Asynchronous reset mid-operation; redirect still follows inputs
      rst = 1'b1;
      ertn_submit = 1'b1;
      redir_q.push_back(32'h0);
      push_chk("t64_in_reset", K_T64, 64'd0);
      push_chk("has_int_in_reset", K_INT, 64'd0);
      rd(CSR_CRMD, 32'h8, "crmd_in_reset");
      ertn_submit = 1'b0;
      hw_int_in = 8'h0;
      rst = 1'b0;
      push_chk("tid_after_reset", K_TID, 64'(TID_P));
      rd(CSR_EENTRY, EENTRY_P, "eentry_after_reset");

      tick();
      tick();
      if (chk_q.size() != 0 || redir_q.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL queue_drain: got %0d/%0d pending, required 0/0", chk_q.size(), redir_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
